final_top: RTL and testbench
============================

Name: final_top

Overview:
- Self-contained compute block with a 64 x 32-bit word memory (256 bytes) and a processing core.
- A host port loads the memory.
- After a Go pulse, the core walks all 64 words in order.
- For each word it emits one 20-bit result (the sum of squares of the word's four bytes), qualified by a one-cycle Done pulse.

Parameters:
- A_WIDTH, 8: byte-address width; memory holds 2**(A_WIDTH-2)=64 words.
- D_WIDTH, 8: byte width.
- ITR, 64: number of results produced per run (one per word).
- R_WIDTH, 20: result width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  reset, asynchronous, active-low. Clears all core state; memory contents are not cleared.
- Go_t  in  1  start pulse; sampled only in IDLE.
- Done_t  out  1  one-cycle pulse; Result is valid in that cycle.
- Result  out  20  sum of squares of current word's bytes.
- M_di32  in  32  host write data.
- M_di8  out  8  byte currently fed to the core's multiplier (debug/observe).
- M_do32  out  32  host read data.
- M_Addr6  in  6  host word address.
- M_enb  in  1  host port enable.
- M_web  in  1  host write enable (1=write, 0=read).

Behaviour:
- Reset values: Done_t=0, Result=0, M_di8=0, M_do32=0, FSM=IDLE, word index=0, accumulator=0.
- Host write: in IDLE, at a rising edge with M_enb=1 and M_web=1, mem[M_Addr6] <= M_di32.
- Host read: in IDLE, at a rising edge with M_enb=1 and M_web=0, M_do32 <= mem[M_Addr6] (1-cycle latency). M_do32 holds otherwise.
- Host accesses are ignored while the core is busy (any state other than IDLE).
- Byte order: byte k of a word = bits [8k+7:8k], k=0..3. Byte 0 is the lowest byte address.
- FSM states and transitions:
  - IDLE: Go_t=1 -> FETCH, with index=0 and acc=0.
  - FETCH: issue synchronous read of mem[index] -> LOAD.
  - LOAD: latch the word into the core register; k=0 -> MAC.
  - MAC: 4 cycles. Each cycle M_di8 <= byte k and acc <= acc + byte_k*byte_k (8x8 unsigned -> 16 bits, zero-extended to 20); k increments. After k=3 -> OUT.
  - OUT: Result <= acc, Done_t=1 for exactly this cycle, acc <= 0. If index=ITR-1 -> IDLE; else index+1 -> FETCH.
- Per-result latency: 7 cycles. Consecutive Done pulses are therefore at least 7 cycles apart; Done_t is never high two cycles in a row.
- Result holds its value between Done pulses and after the run ends.
- Width: maximum value 4*255^2 = 260100 = 0x3F804, which fits in 20 bits; no overflow handling is needed.
- Go_t asserted while busy is ignored. Go_t in IDLE after a completed run starts a new run from index 0.
- Rst asserted mid-run aborts immediately: FSM=IDLE, Done_t=0, Result=0; memory contents are retained.
- Simultaneous Go_t and a host access in IDLE: the host access completes in that cycle, and the core starts.

Decomposition:
- Shared package final_pkg: A_WIDTH, D_WIDTH, ITR, R_WIDTH, derived WORDS=64, and the FSM state enum (IDLE, FETCH, LOAD, MAC, OUT).
- One sub-module, final_mem: 64x32 single-port synchronous RAM.
  - Address/data/write-enable are muxed between host (IDLE) and core (busy).
- Core FSM and MAC datapath stay in final_top.

Test Plan:
- Reset values: assert Rst=0 for 2 cycles -> Done_t=0, Result=0, M_do32=0. No Done_t pulse while idle.
- Host write/readback:
  - Write mem[5]=0xDEADBEEF, then read addr 5 -> M_do32=0xDEADBEEF one cycle after the read edge.
  - Other addresses are unchanged.
- Full run:
  - Load word0=0x01020304, word1=0xFFFFFFFF, word2=0, words 3..63 = 0x00000002. Pulse Go_t.
  - Expect 64 single-cycle Done_t pulses with Result: 0x0001E, 0x3F804, 0x00000, then 0x00004 x61.
  - After the 64th pulse, FSM returns to IDLE and no further pulses occur.
- Spacing: measure cycles between Done_t pulses -> exactly 7.
  - A bench that waits one cycle after each Done before polling again must still see all 64 results.
- Go_t while busy: pulse Go_t mid-run -> sequence is unaffected, still exactly 64 results.
  - A second Go_t after completion -> an identical 64-result sequence.
- Reset mid-run: assert Rst after the 10th Done -> outputs cleared immediately.
  - A new Go_t then restarts from word 0 with memory intact (first Result=0x0001E).

Source files
------------

// File: rtl/final_pkg.sv
// final_pkg: shared parameters, FSM state type and helpers for the
// final_top compute block (64-word memory + sum-of-squares core).
package final_pkg;

  localparam int A_WIDTH = 8;               // byte-address width
  localparam int D_WIDTH = 8;               // byte width
  localparam int ITR     = 64;              // results per run
  localparam int R_WIDTH = 20;              // result width

  localparam int W_AW    = A_WIDTH - 2;     // word-address width
  localparam int WORDS   = 2 ** W_AW;       // words in memory
  localparam int WORD_W  = 4 * D_WIDTH;     // bits per word

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    MAC,
    OUT
  } state_t;

  // Square of one unsigned byte, zero-extended to the result width.
  function automatic logic [R_WIDTH-1:0] byte_sq(input logic [D_WIDTH-1:0] b);
    logic [2*D_WIDTH-1:0] p;
    p = b * b;
    return R_WIDTH'(p);
  endfunction

endpackage

// File: rtl/final_mem.sv
// final_mem: 64 x 32-bit single-port synchronous RAM.
// Ports:
//   Clk_s  - rising-edge clock
//   en     - port enable
//   we     - write enable (1 = write, 0 = read)
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data; holds when no read is issued
// Contents are never reset.
module final_mem
  import final_pkg::*;
(
  input  logic              Clk_s,
  input  logic              en,
  input  logic              we,
  input  logic [W_AW-1:0]   addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [WORDS];

  always_ff @(posedge Clk_s) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/final_top.sv
// final_top: compute block that walks all 64 memory words after a Go pulse
// and emits, per word, the sum of squares of its four bytes.
// Ports:
//   Clk     - rising-edge clock
//   Rst     - asynchronous active-low reset (memory contents retained)
//   Go_t    - start pulse, only honoured in IDLE
//   Done_t  - one-cycle pulse, Result valid in the same cycle
//   Result  - sum of squares of the current word's bytes
//   M_di32  - host write data
//   M_di8   - byte most recently fed to the multiplier (observe)
//   M_do32  - host read data (one cycle after the read edge, then held)
//   M_Addr6 - host word address
//   M_enb   - host port enable
//   M_web   - host write enable (1 = write, 0 = read)
module final_top
  import final_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Go_t,
  output logic               Done_t,
  output logic [R_WIDTH-1:0] Result,
  input  logic [WORD_W-1:0]  M_di32,
  output logic [D_WIDTH-1:0] M_di8,
  output logic [WORD_W-1:0]  M_do32,
  input  logic [W_AW-1:0]    M_Addr6,
  input  logic               M_enb,
  input  logic               M_web
);

  state_t             state;
  logic [W_AW-1:0]    word_idx;
  logic [1:0]         byte_k;
  logic [R_WIDTH-1:0] acc;
  logic [WORD_W-1:0]  core_word;
  logic [D_WIDTH-1:0] cur_byte;

  logic               busy;
  logic               mem_en;
  logic               mem_we;
  logic [W_AW-1:0]    mem_addr;
  logic [WORD_W-1:0]  mem_rdata;

  logic               host_rd_q;
  logic [WORD_W-1:0]  do_q;

  // The host owns the RAM port in IDLE; once running, the core owns it and
  // only reads, during FETCH.
  always_comb begin
    busy     = (state != IDLE);
    mem_en   = busy ? (state == FETCH) : M_enb;
    mem_we   = busy ? 1'b0 : M_web;
    mem_addr = busy ? word_idx : M_Addr6;
  end

  always_comb begin
    cur_byte = core_word[byte_k*D_WIDTH +: D_WIDTH];
  end

  final_mem u_mem (
    .Clk_s (Clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (M_di32),
    .rdata (mem_rdata)
  );

  // The RAM output register is shared with core fetches, so host read data
  // is shown straight from it in the cycle after the read and captured into
  // do_q so it keeps holding once the core starts reading.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      host_rd_q <= 1'b0;
      do_q      <= '0;
    end else begin
      host_rd_q <= !busy && M_enb && !M_web;
      if (host_rd_q) begin
        do_q <= mem_rdata;
      end
    end
  end

  assign M_do32 = host_rd_q ? mem_rdata : do_q;

  // Core sequencer: FETCH issues the read, LOAD captures the word, MAC takes
  // four cycles (one byte each), OUT publishes the sum. Done_t is registered,
  // so it is high in the cycle after OUT together with the new Result, which
  // gives a fixed seven-cycle spacing between results.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      word_idx  <= '0;
      byte_k    <= '0;
      acc       <= '0;
      core_word <= '0;
      Done_t    <= 1'b0;
      Result    <= '0;
      M_di8     <= '0;
    end else begin
      Done_t <= 1'b0;
      case (state)
        IDLE: begin
          if (Go_t) begin
            word_idx <= '0;
            acc      <= '0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          core_word <= mem_rdata;
          byte_k    <= '0;
          state     <= MAC;
        end
        MAC: begin
          M_di8  <= cur_byte;
          acc    <= acc + byte_sq(cur_byte);
          byte_k <= byte_k + 2'd1;
          if (byte_k == 2'd3) begin
            state <= OUT;
          end
        end
        OUT: begin
          Result <= acc;
          Done_t <= 1'b1;
          acc    <= '0;
          if (word_idx == W_AW'(ITR - 1)) begin
            state <= IDLE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_final_top.sv
// tb_final_top: directed, table-driven bench for final_top. Host port
// vectors come from a record table; full runs, Go while busy, reruns and
// mid-run reset are hand-written sequences checked against constant
// expected results.
module tb_final_top;
  import final_pkg::*;

  logic               Clk;
  logic               Rst;
  logic               Go_t;
  logic               Done_t;
  logic [R_WIDTH-1:0] Result;
  logic [WORD_W-1:0]  M_di32;
  logic [D_WIDTH-1:0] M_di8;
  logic [WORD_W-1:0]  M_do32;
  logic [W_AW-1:0]    M_Addr6;
  logic               M_enb;
  logic               M_web;

  int compared   = 0;
  int mismatched = 0;

  final_top dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Go_t    (Go_t),
    .Done_t  (Done_t),
    .Result  (Result),
    .M_di32  (M_di32),
    .M_di8   (M_di8),
    .M_do32  (M_do32),
    .M_Addr6 (M_Addr6),
    .M_enb   (M_enb),
    .M_web   (M_web)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic              en;
    logic              we;
    logic [W_AW-1:0]   addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] exp_do;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic we,
                               input logic [W_AW-1:0] addr,
                               input logic [WORD_W-1:0] wdata);
    M_enb   = en;
    M_web   = we;
    M_Addr6 = addr;
    M_di32  = wdata;
  endtask

  function automatic logic [R_WIDTH-1:0] expResult(input int n);
    if (n == 0)      return 20'h0001E;
    else if (n == 1) return 20'h3F804;
    else if (n == 2) return 20'h00000;
    else             return 20'h00004;
  endfunction

  // Highest byte of word n, which is the last byte fed before its Done.
  function automatic logic [D_WIDTH-1:0] expTopByte(input int n);
    if (n == 0)      return 8'h01;
    else if (n == 1) return 8'hFF;
    else             return 8'h00;
  endfunction

  // Pulse Go, then watch for Done pulses until stop_after results are seen
  // or the cycle budget runs out. A full run also checks that no extra
  // pulse follows.
  task automatic runSequence(input int stop_after, input bit go_mid,
                             input string tag);
    int n = 0;
    int last = 0;
    int cyc = 0;
    int extra = 0;
    @(negedge Clk) Go_t = 1'b1;
    @(negedge Clk) Go_t = 1'b0;
    while (n < stop_after && cyc < ITR * 7 + 40) begin
      @(negedge Clk);
      cyc++;
      Go_t = (go_mid && cyc == 100);
      if (Done_t) begin
        checkOutput({tag, " result"}, 32'(Result), 32'(expResult(n)));
        checkOutput({tag, " di8"}, 32'(M_di8), 32'(expTopByte(n)));
        if (n > 0) checkOutput({tag, " spacing"}, cyc - last, 7);
        last = cyc;
        n++;
      end
    end
    Go_t = 1'b0;
    checkOutput({tag, " count"}, n, stop_after);
    if (stop_after == ITR) begin
      repeat (30) begin
        @(negedge Clk);
        if (Done_t) extra++;
      end
      checkOutput({tag, " extra done"}, extra, 0);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 6'd4, 32'hA5A5A5A5, 32'h00000000};
    vecs[1] = '{1'b1, 1'b1, 6'd5, 32'hDEADBEEF, 32'h00000000};
    vecs[2] = '{1'b1, 1'b1, 6'd6, 32'h12345678, 32'h00000000};
    vecs[3] = '{1'b1, 1'b0, 6'd5, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 6'd4, 32'h0,        32'hA5A5A5A5};
    vecs[5] = '{1'b1, 1'b0, 6'd6, 32'h0,        32'h12345678};
    vecs[6] = '{1'b0, 1'b0, 6'd5, 32'h0,        32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 6'd5, 32'h0,        32'hDEADBEEF};

    Rst  = 1'b0;
    Go_t = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge Clk);
    checkOutput("reset Done_t", 32'(Done_t), 0);
    checkOutput("reset Result", 32'(Result), 0);
    checkOutput("reset M_do32", M_do32, 0);
    checkOutput("reset M_di8", 32'(M_di8), 0);
    Rst = 1'b1;

    $display("[TB] host port vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(negedge Clk);
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("vec%0d M_do32", i), M_do32, vecs[i].exp_do);
      checkOutput($sformatf("vec%0d idle Done_t", i), 32'(Done_t), 0);
    end

    $display("[TB] loading run pattern");
    for (int w = 0; w < WORDS; w++) begin
      if (w == 0)      applyStimulus(1'b1, 1'b1, W_AW'(w), 32'h01020304);
      else if (w == 1) applyStimulus(1'b1, 1'b1, W_AW'(w), 32'hFFFFFFFF);
      else if (w == 2) applyStimulus(1'b1, 1'b1, W_AW'(w), 32'h00000000);
      else             applyStimulus(1'b1, 1'b1, W_AW'(w), 32'h00000002);
      @(negedge Clk);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);

    $display("[TB] full run");
    runSequence(ITR, 1'b0, "run1");

    $display("[TB] run with Go while busy");
    runSequence(ITR, 1'b1, "run2");

    $display("[TB] abort by reset after 10 results");
    runSequence(10, 1'b0, "abort");
    Rst = 1'b0;
    #1;
    checkOutput("abort Done_t", 32'(Done_t), 0);
    checkOutput("abort Result", 32'(Result), 0);
    checkOutput("abort M_do32", M_do32, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);

    $display("[TB] restart after reset");
    runSequence(ITR, 1'b0, "restart");

    applyStimulus(1'b1, 1'b0, 6'd1, '0);
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("post-run read word1", M_do32, 32'hFFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
